// File: rtl/decoder_scan.sv
`default_nettype none
// ============================================================================
// Module   : decoder_scan
// Summary  : Registered SEL_W-to-2^SEL_W one-hot decoder with a valid/ready
//            direct-select port and an auto-scan mode with programmable dwell.
//            Define DECODER_ACTIVE_LOW_EN for an inverted (active-low) out port.
// Revision : 1.0  initial release
// ============================================================================
module decoder_scan #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  sel_valid,
  input  logic [SEL_W-1:0]      sel,
  output logic                  sel_ready,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] out,
  output logic [SEL_W-1:0]      out_idx,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam logic [SEL_W-1:0] c_idx_max = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t             r_state, w_state_n;
  logic [SEL_W-1:0]   r_idx, w_idx_n;
  logic [DWELL_W-1:0] r_cnt, w_cnt_n;
  logic               r_act, w_act_n;
  logic               r_gated, w_gated_n;
  logic               r_wrap, w_wrap_n;
  logic [OUT_W-1:0]   r_onehot, w_onehot_n;
  logic               w_accept;

  assign sel_ready = en & ~mode & ~rst;
  assign w_accept  = sel_valid & sel_ready;

  // r_act remembers whether a decode is logically active, so re-enabling
  // restores exactly what was shown before the block was disabled.
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_cnt_n   = r_cnt;
    w_act_n   = r_act;
    w_gated_n = r_gated;
    w_wrap_n  = 1'b0;
    if (!en) begin
      w_gated_n = 1'b1;
    end else begin
      w_gated_n = 1'b0;
      if (w_accept) begin
        w_state_n = ST_DIRECT;
        w_idx_n   = sel;
        w_act_n   = 1'b1;
      end else if (mode) begin
        if (r_state != ST_SCAN) begin
          w_state_n = ST_SCAN;
          w_idx_n   = '0;
          w_cnt_n   = '0;
          w_act_n   = 1'b1;
        end else if (!r_gated) begin
          // the first edge after re-enable only restores the output
          if (r_cnt == dwell) begin
            w_cnt_n  = '0;
            w_idx_n  = r_idx + SEL_W'(1);
            w_wrap_n = (r_idx == c_idx_max);
          end else begin
            w_cnt_n = r_cnt + DWELL_W'(1);
          end
        end
      end else if (r_state != ST_DIRECT) begin
        w_state_n = ST_DIRECT;
        w_idx_n   = '0;
        w_act_n   = 1'b0;
      end
    end
    w_onehot_n = (en && w_act_n) ? (OUT_W'(1) << w_idx_n) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_act    <= 1'b0;
      r_gated  <= 1'b0;
      r_wrap   <= 1'b0;
      r_onehot <= '0;
    end else begin
      r_state  <= w_state_n;
      r_idx    <= w_idx_n;
      r_cnt    <= w_cnt_n;
      r_act    <= w_act_n;
      r_gated  <= w_gated_n;
      r_wrap   <= w_wrap_n;
      r_onehot <= w_onehot_n;
    end
  end

`ifdef DECODER_ACTIVE_LOW_EN
  assign out = ~r_onehot;
`else
  assign out = r_onehot;
`endif
  assign out_idx = r_idx;
  assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan.sv
`default_nettype none
// Testbench for decoder_scan (SEL_W=2, DWELL_W=8): vector table driven through
// a scoreboard queue, plus a hand-written dwell-shrink sequence.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst, en, mode, sel_valid, sel_ready, wrap;
  logic [1:0] sel, out_idx;
  logic [7:0] dwell;
  logic [3:0] out;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(2), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .sel_valid(sel_valid), .sel(sel), .sel_ready(sel_ready),
    .dwell(dwell), .out(out), .out_idx(out_idx), .wrap(wrap)
  );

  typedef struct {
    logic       rst, en, mode, sv;
    logic [1:0] sel;
    logic [7:0] dwell;
    logic       rdy;
    logic [3:0] out;
    logic [1:0] idx;
    logic       w;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(logic r, logic e, logic m, logic v, logic [1:0] s,
                              logic [7:0] d, logic rdy, logic [3:0] o,
                              logic [1:0] i, logic w);
    vec_t t;
    t.rst = r; t.en = e; t.mode = m; t.sv = v; t.sel = s; t.dwell = d;
    t.rdy = rdy; t.out = o; t.idx = i; t.w = w;
    return t;
  endfunction

  function automatic logic [3:0] phys(logic [3:0] v);
`ifdef DECODER_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
    $fatal(1);
  end

  initial begin
    vec_t e;
    bit   moved;
    rst = 1'b1; en = 1'b1; mode = 1'b0; sel_valid = 1'b0; sel = '0; dwell = 8'd2;

    //               rst en md sv sel  dwell rdy out      idx wrap
    tbl.push_back(mk(1, 1, 0, 0, 2'd0, 8'd2, 0, 4'b0000, 0, 0)); // reset
    tbl.push_back(mk(1, 1, 0, 0, 2'd0, 8'd2, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'd0, 8'd2, 1, 4'b0000, 0, 0)); // idle->direct
    tbl.push_back(mk(0, 1, 0, 1, 2'd0, 8'd2, 1, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 2'd1, 8'd2, 1, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 2'd2, 8'd2, 1, 4'b0100, 2, 0));
    tbl.push_back(mk(0, 1, 0, 1, 2'd3, 8'd2, 1, 4'b1000, 3, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'd1, 8'd2, 1, 4'b1000, 3, 0)); // hold
    tbl.push_back(mk(0, 1, 0, 0, 2'd1, 8'd2, 1, 4'b1000, 3, 0));
    tbl.push_back(mk(0, 1, 1, 1, 2'd1, 8'd2, 0, 4'b0001, 0, 0)); // scan entry
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 0, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 0, 4'b0001, 0, 0));
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++)
        tbl.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 0, 4'(1 << (k + 1)), 2'(k + 1), 0));
    end
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 8'd2, 0, 4'b0001, 0, 1)); // wrap
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 8'd0, 0, 4'b0010, 1, 0)); // dwell=0
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 8'd0, 0, 4'b0100, 2, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2'd0, 8'd0, 0, 4'b0000, 2, 0)); // disabled
    tbl.push_back(mk(0, 0, 1, 0, 2'd0, 8'd0, 0, 4'b0000, 2, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2'd0, 8'd0, 0, 4'b0000, 2, 0));
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 8'd0, 0, 4'b0100, 2, 0)); // restore
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 8'd0, 0, 4'b1000, 3, 0));
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 8'd0, 0, 4'b0001, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 8'd0, 0, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 2'd3, 8'd0, 0, 4'b0100, 2, 0)); // pending sel refused
    tbl.push_back(mk(0, 1, 0, 0, 2'd3, 8'd0, 1, 4'b0000, 0, 0)); // scan->direct
    tbl.push_back(mk(0, 1, 0, 1, 2'd3, 8'd0, 1, 4'b1000, 3, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'd0, 8'd0, 1, 4'b1000, 3, 0));
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 8'd0, 0, 4'b0001, 0, 0)); // scan again
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 8'd0, 0, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 8'd0, 0, 4'b0100, 2, 0));
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 8'd0, 0, 4'b1000, 3, 0));
    tbl.push_back(mk(1, 1, 1, 0, 2'd0, 8'd0, 0, 4'b0000, 0, 0)); // reset mid-scan
    tbl.push_back(mk(0, 1, 0, 1, 2'd1, 8'd0, 1, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2'd2, 8'd0, 0, 4'b0000, 1, 0)); // disabled direct
    tbl.push_back(mk(0, 1, 0, 0, 2'd0, 8'd0, 1, 4'b0010, 1, 0));

    foreach (tbl[r]) begin
      @(negedge clk);
      rst = tbl[r].rst; en = tbl[r].en; mode = tbl[r].mode;
      sel_valid = tbl[r].sv; sel = tbl[r].sel; dwell = tbl[r].dwell;
      #1;
      if (r >= 2) chk("sel_ready", r, 32'(sel_ready), 32'(tbl[r].rdy));
      sb.push_back(tbl[r]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("out", r, 32'(out), 32'(phys(e.out)));
      chk("out_idx", r, 32'(out_idx), 32'(e.idx));
      chk("wrap", r, 32'(wrap), 32'(e.w));
    end

    // Shrinking dwell below the running count: counter rolls past all-ones.
    @(negedge clk);
    mode = 1'b1; sel_valid = 1'b0; dwell = 8'd5;
    @(posedge clk); #1;
    chk("shrink_entry_idx", 0, 32'(out_idx), 32'd0);
    for (int k = 0; k < 4; k++) @(posedge clk);
    @(negedge clk);
    dwell = 8'd1;
    moved = 1'b0;
    for (int k = 0; k < 253; k++) begin
      @(posedge clk); #1;
      if (out_idx !== 2'd0) moved = 1'b1;
    end
    chk("shrink_hold", 253, 32'(moved), 32'd0);
    @(posedge clk); #1;
    chk("shrink_step_idx", 254, 32'(out_idx), 32'd1);
    chk("shrink_step_out", 254, 32'(out), 32'(phys(4'b0010)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
- Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder.
- Next generation of the team's 2-to-4 decoder: adds a clock, an enable, a valid/ready select handshake and an auto-scan mode.
- In scan mode the active output steps through all outputs with a programmable dwell time.
- Used for display digit multiplexing and row strobing in the lab designs.

Parameters:
- SEL_W, 2, select width; output width OUT_W = 2**SEL_W (derived localparam, not overridable).
- DWELL_W, 8, width of the dwell-count input.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  block enable; 0 forces outputs inactive and freezes state.
- mode  input  1  0 = direct decode, 1 = auto scan.
- sel_valid  input  1  sel is presented.
- sel  input  SEL_W  index to decode (direct mode).
- sel_ready  output  1  block accepts sel this cycle.
- dwell  input  DWELL_W  scan dwell; each index is held dwell+1 cycles.
- out  output  OUT_W  registered one-hot decode.
- out_idx  output  SEL_W  index currently driven.
- wrap  output  1  one-cycle pulse when scan index wraps to 0.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high and overrides everything, including mid-scan and mid-handshake.
- Reset values: out=0, out_idx=0, wrap=0, dwell counter=0, state=IDLE.
- States:
  - IDLE: out=0. mode=0 -> DIRECT; mode=1 -> SCAN.
  - DIRECT: follows accepted selects.
  - SCAN: free-running stepping.
- sel_ready: combinational = en & ~mode & ~rst.
- Direct mode:
  - Accept on sel_valid & sel_ready.
  - Next cycle: out = 1<<sel, out_idx=sel (latency 1). Value held until the next accept.
  - sel_valid without ready is ignored; no buffering.
- Scan mode:
  - On entry, the next cycle has out_idx=0, out=1, dwell counter=0.
  - Counter increments each cycle. When counter==dwell: counter->0, out_idx -> out_idx+1 modulo OUT_W, out updated in the same edge.
  - dwell=0: advances every cycle.
  - dwell is sampled every cycle. Changing it mid-dwell takes effect at the next comparison. If the counter already exceeds the new dwell, it continues to all-ones, wraps, and then matches.
- wrap: asserted for exactly the one cycle in which out_idx becomes 0 from OUT_W-1. Never asserted in direct mode or on scan entry.
- Mode switch:
  - Takes effect on the next edge.
  - SCAN->DIRECT: out=0, out_idx=0 until the first accepted sel.
  - DIRECT->SCAN: any pending sel is not accepted, because ready drops in that cycle.
- en=0:
  - out=0 from the next edge; out_idx, counter and state frozen; wrap=0.
  - On en=1, the prior out_idx is restored to out the next cycle (scan resumes with the same counter value).
- Invariant: out is always zero or exactly one-hot, and out[out_idx]=1 whenever out!=0.

Optional Feature:
- Macro: DECODER_ACTIVE_LOW_EN (for common-anode digit drivers).
- Defined: the out port is the bitwise inverse of the internal one-hot. Reset, idle and disabled value is all ones; the active output is 0.
- Undefined: active-high as above.
- out_idx, wrap and the handshake are unaffected in both cases.

Test Plan (SEL_W=2):
- rst=1 for 2 cycles, then release with en=1, mode=0, no sel -> out=4'b0000, out_idx=0, wrap=0, sel_ready=1.
- Direct: sel=2'b00..2'b11 each with sel_valid for 1 cycle -> one cycle later out=0001, 0010, 0100, 1000 in turn. With sel_valid=0, out holds 1000.
- Scan, dwell=2: out sequence 0001×3, 0010×3, 0100×3, 1000×3, 0001. wrap=1 only on the cycle out returns to 0001.
- Scan, dwell=0: out changes every cycle. en dropped for 3 cycles at out_idx=2 -> out=0000, then 0100 resumes and the sequence continues.
- Mode 1->0 mid-scan with sel_valid=1, sel=3 on the switch cycle -> sel_ready=0 that cycle, out=0000. Next-cycle handshake -> out=1000.
- rst pulsed during scan at out_idx=3 -> all outputs return to reset values next cycle. With DECODER_ACTIVE_LOW_EN defined, the first scenario shows out=1111 and direct sel=1 gives out=1101.
